// File: rtl/bundle_fifo.sv
// bundle_fifo: small valid/ready FIFO with optional empty-queue bypass.
// Define BUNDLE_FIFO_ASSERT_EN to compile the simulation-only protocol checks.
module bundle_fifo #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 2,
  parameter bit          BYPASS_EN = 1'b1,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              enq_valid_i,
  output logic              enq_ready_o,
  input  logic [DATA_W-1:0] enq_data_i,
  output logic              deq_valid_o,
  input  logic              deq_ready_i,
  output logic [DATA_W-1:0] deq_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic enq_fire;
  logic deq_fire;
  logic bypass;
  logic wr_en;
  logic rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign enq_ready_o = !full_o && !flush_i;

  always_comb begin
    deq_valid_o = 1'b0;
    deq_data_o  = '0;
    if (!empty_o) begin
      deq_valid_o = !flush_i;
      deq_data_o  = mem_q[head_q];
    end else if (BYPASS_EN) begin
      deq_valid_o = enq_valid_i && !flush_i;
      deq_data_o  = enq_data_i;
    end
  end

  assign enq_fire = enq_valid_i && enq_ready_o;
  assign deq_fire = deq_valid_o && deq_ready_i;

  // An empty queue that hands the offer straight through stores nothing.
  assign bypass = BYPASS_EN && empty_o && deq_fire;
  assign wr_en  = enq_fire && !bypass;
  assign rd_en  = deq_fire && !empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr_en) tail_d = ptr_inc(tail_q);
      if (rd_en) head_d = ptr_inc(head_q);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && wr_en) mem_q[tail_q] <= enq_data_i;
  end

`ifdef BUNDLE_FIFO_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(enq_fire && full_o))
        else $error("bundle_fifo: enqueue while full");
      assert (!(deq_ready_i && deq_fire && !deq_valid_o))
        else $error("bundle_fifo: dequeue fire without valid");
      assert (32'(count_q) <= DEPTH)
        else $error("bundle_fifo: count exceeds depth");
    end
  end
`else
`endif

endmodule

// File: tb/tb_bundle_fifo.sv
// tb_bundle_fifo: directed vector table for the bypass build plus
// hand sequences for reset and the registered (no-bypass) build.
module tb_bundle_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, enq_v, deq_r;
  logic [7:0] enq_d;
  logic       enq_rdy, deq_v, full, empty;
  logic [7:0] deq_d;
  logic [1:0] cnt;

  logic       nb_flush, nb_enq_v, nb_deq_r;
  logic [7:0] nb_enq_d;
  logic       nb_enq_rdy, nb_deq_v, nb_full, nb_empty;
  logic [7:0] nb_deq_d;
  logic [1:0] nb_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bundle_fifo #(.DATA_W(8), .DEPTH(2), .BYPASS_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .enq_valid_i(enq_v), .enq_ready_o(enq_rdy), .enq_data_i(enq_d),
    .deq_valid_o(deq_v), .deq_ready_i(deq_r), .deq_data_o(deq_d),
    .count_o(cnt), .full_o(full), .empty_o(empty)
  );

  bundle_fifo #(.DATA_W(8), .DEPTH(2), .BYPASS_EN(1'b0)) u_nb (
    .clk(clk), .rst(rst), .flush_i(nb_flush),
    .enq_valid_i(nb_enq_v), .enq_ready_o(nb_enq_rdy), .enq_data_i(nb_enq_d),
    .deq_valid_o(nb_deq_v), .deq_ready_i(nb_deq_r), .deq_data_o(nb_deq_d),
    .count_o(nb_cnt), .full_o(nb_full), .empty_o(nb_empty)
  );

  typedef struct {
    logic       fl;
    logic       ev;
    logic [7:0] ed;
    logic       dr;
    logic       er;
    logic       edv;
    logic [7:0] edd;
    logic [1:0] ec;
    logic       ef;
    logic       ee;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic ev,
                       input logic [7:0] ed, input logic dr);
    @(negedge clk);
    flush = fl;
    enq_v = ev;
    enq_d = ed;
    deq_r = dr;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 0; enq_v = 0; enq_d = 0; deq_r = 0;
    nb_flush = 0; nb_enq_v = 0; nb_enq_d = 0; nb_deq_r = 0;

    //          fl ev ed     dr er dv edd    cnt f  e
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 1, 8'hA5, 1, 1, 1, 8'hA5, 0, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 1, 8'h11, 0, 1, 1, 8'h11, 0, 0, 1});
    tbl.push_back('{0, 1, 8'h22, 0, 1, 1, 8'h11, 1, 0, 0});
    tbl.push_back('{0, 1, 8'h33, 0, 0, 1, 8'h11, 2, 1, 0});
    tbl.push_back('{0, 1, 8'h33, 1, 0, 1, 8'h11, 2, 1, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h22, 1, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 1, 8'h01, 0, 1, 1, 8'h01, 0, 0, 1});
    tbl.push_back('{0, 1, 8'h02, 1, 1, 1, 8'h01, 1, 0, 0});
    tbl.push_back('{0, 1, 8'h03, 1, 1, 1, 8'h02, 1, 0, 0});
    tbl.push_back('{0, 1, 8'h04, 1, 1, 1, 8'h03, 1, 0, 0});
    tbl.push_back('{0, 1, 8'h05, 1, 1, 1, 8'h04, 1, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h05, 1, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{1, 1, 8'h44, 1, 0, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 1, 8'h66, 0, 1, 1, 8'h66, 0, 0, 1});
    tbl.push_back('{0, 1, 8'h77, 0, 1, 1, 8'h66, 1, 0, 0});
    tbl.push_back('{1, 1, 8'h88, 1, 0, 0, 8'h00, 2, 1, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{0, 1, 8'h99, 0, 1, 1, 8'h99, 0, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 8'h99, 1, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 1});

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].fl, tbl[i].ev, tbl[i].ed, tbl[i].dr);
      chk($sformatf("v%0d enq_ready", i), 8'(enq_rdy), 8'(tbl[i].er));
      chk($sformatf("v%0d deq_valid", i), 8'(deq_v), 8'(tbl[i].edv));
      if (tbl[i].edv)
        chk($sformatf("v%0d deq_data", i), deq_d, tbl[i].edd);
      chk($sformatf("v%0d count", i), 8'(cnt), 8'(tbl[i].ec));
      chk($sformatf("v%0d full", i), 8'(full), 8'(tbl[i].ef));
      chk($sformatf("v%0d empty", i), 8'(empty), 8'(tbl[i].ee));
    end

    // Reset with one stored entry discards it.
    drive(0, 1, 8'h5A, 0);
    drive(0, 0, 8'h00, 0);
    chk("rst_pre count", 8'(cnt), 8'd1);
    rst = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst count", 8'(cnt), 8'd0);
    chk("rst empty", 8'(empty), 8'd1);
    chk("rst deq_valid", 8'(deq_v), 8'd0);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    chk("rst drained", 8'(deq_v), 8'd0);
    chk("rst count2", 8'(cnt), 8'd0);

    // Registered build: one-cycle enqueue-to-dequeue latency.
    @(negedge clk);
    nb_enq_v = 1; nb_enq_d = 8'h3C; nb_deq_r = 1;
    #1;
    chk("nb reset empty", 8'(nb_empty), 8'd1);
    chk("nb enq_ready", 8'(nb_enq_rdy), 8'd1);
    chk("nb deq_valid0", 8'(nb_deq_v), 8'd0);
    chk("nb deq_data0", nb_deq_d, 8'h00);
    @(negedge clk);
    nb_enq_v = 0; nb_enq_d = 8'h00; nb_deq_r = 0;
    #1;
    chk("nb deq_valid1", 8'(nb_deq_v), 8'd1);
    chk("nb deq_data1", nb_deq_d, 8'h3C);
    chk("nb count1", 8'(nb_cnt), 8'd1);
    @(negedge clk);
    nb_deq_r = 1;
    @(negedge clk);
    nb_deq_r = 0;
    #1;
    chk("nb count0", 8'(nb_cnt), 8'd0);
    chk("nb empty", 8'(nb_empty), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bundle_fifo.md
BUNDLE_FIFO -- requirements
Module: bundle_fifo

Interface
REQ-001 Parameter DATA_W, default 32, width of one stored bundle in bits (>=1).
REQ-002 Parameter DEPTH, default 2, number of storage entries (>=1, not required to be a power of two).
REQ-003 Parameter BYPASS_EN, default 1'b1, enables empty-queue combinational pass-through from enqueue to dequeue.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 flush_i  input  1  synchronous discard of all stored entries.
REQ-007 enq_valid_i  input  1  producer offers enq_data_i.
REQ-008 enq_ready_o  output  1  queue accepts the offer this cycle.
REQ-009 enq_data_i  input  DATA_W  bundle to enqueue.
REQ-010 deq_valid_o  output  1  deq_data_o holds a valid bundle.
REQ-011 deq_ready_i  input  1  consumer takes the bundle this cycle.
REQ-012 deq_data_o  output  DATA_W  oldest bundle (or the bypassed bundle).
REQ-013 count_o  output  $clog2(DEPTH+1)  number of stored entries, excluding any bypassed bundle.
REQ-014 full_o  output  1  count_o == DEPTH.
REQ-015 empty_o  output  1  count_o == 0.

Function
REQ-016 Enqueue fire = enq_valid_i && enq_ready_o; dequeue fire = deq_valid_o && deq_ready_i.
REQ-017 enq_ready_o SHALL be !full_o && !flush_i; no enqueue into a full queue even if a dequeue fires in the same cycle.
REQ-018 Stored data SHALL leave in FIFO order; head/tail pointers wrap from DEPTH-1 to 0.
REQ-019 When count_o > 0: deq_valid_o = !flush_i, deq_data_o = head entry.
REQ-020 When count_o == 0 and BYPASS_EN=1: deq_valid_o = enq_valid_i && !flush_i, deq_data_o = enq_data_i; if deq_ready_i is also high, the bundle passes through and nothing is written (count stays 0).
REQ-021 When count_o == 0 and BYPASS_EN=0: deq_valid_o = 0, deq_data_o = 0; latency from enqueue to deq_valid_o is one cycle.
REQ-022 Enqueue without dequeue: count +1. Dequeue of stored entry without enqueue: count -1. Both fire with count > 0: count unchanged, head and tail both advance.
REQ-023 count_o, full_o, empty_o SHALL be registered-state derived (no combinational dependency on enq_valid_i/deq_ready_i).
REQ-024 flush_i SHALL (next edge) set count, head and tail to 0; during the flush cycle enq_ready_o=0 and deq_valid_o=0; flush has priority over simultaneous enq/deq.
REQ-025 Storage array contents need not be cleared by flush or reset.

Reset
REQ-026 With rst high at a rising edge: count=0, head=0, tail=0; after reset empty_o=1, full_o=0, count_o=0, enq_ready_o=1, deq_valid_o=0 (or enq_valid_i if BYPASS_EN=1).
REQ-027 rst SHALL take priority over flush_i and all handshakes; reset mid-operation discards all entries.

Configuration
REQ-028 Macro BUNDLE_FIFO_ASSERT_EN: when defined, simulation assertions flag enqueue while full, dequeue-fire while deq_valid_o=0, and count_o > DEPTH, each via $error; when undefined, no assertion code is compiled and functional behaviour is identical.

Verification
REQ-029 DATA_W=8, DEPTH=2, BYPASS_EN=1: count 0, enq 0xA5 with deq_ready_i=1 -> same cycle deq_valid_o=1, deq_data_o=0xA5, count_o stays 0.
REQ-030 Enq 0x11, 0x22 with deq_ready_i=0 -> count_o=2, full_o=1, enq_ready_o=0; then deq_ready_i=1 -> outputs 0x11 then 0x22, empty_o=1.
REQ-031 Pointer wrap: 5 alternating enq/deq pairs with count held at 1 (values 1..5) -> outputs 1..5 in order, count_o stays 1.
REQ-032 count_o=2, assert flush_i with enq_valid_i=1 -> enq_ready_o=0, deq_valid_o=0 that cycle; next cycle count_o=0, empty_o=1.
REQ-033 BYPASS_EN=0: count 0, enq 0x3C with deq_ready_i=1 -> deq_valid_o=0 that cycle; next cycle deq_valid_o=1, deq_data_o=0x3C, count_o=1.
REQ-034 Assert rst with count_o=1 -> next cycle count_o=0, empty_o=1, stored bundle never dequeued.
